freq_result_tx: RTL and testbench
=================================

# freq_result_tx

Serial readout transmitter for the frequency/duty counter results. On a start strobe it snapshots the seven 32-bit latched count words and sends them as one framed packet over an 8N1 UART line. The host-side decoder reconstructs the counts from that packet. It runs on the counter clock and sits directly downstream of the counter's result registers; the gate-rise strobe, or any one-cycle pulse, drives `start`.

## Interface

Parameters:
- `BAUD_DIV`, default 1736 — clock cycles per UART bit (200 MHz / 115200, truncated); legal range 2..65535.

Ports:
- `clk200M`  in  1  — sole clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — one-cycle request; snapshot inputs and send one frame.
- `xyr_cnt`, `xyh_cnt`, `xyl_cnt`  in  32 each  — two-channel rise / high / low counts.
- `x_cnt`, `r_cnt`, `xh_cnt`, `xl_cnt`  in  32 each  — single-channel x / reference / high / low counts.
- `txd`  out  1  — UART line; idles high.
- `busy`  out  1  — high from the accept edge until frame end.
- `done`  out  1  — one-cycle pulse when the final stop bit completes.
- `missed`  out  1  — one-cycle pulse when `start` arrives while not idle.

## Operation

- Frame is 31 bytes, with no gaps between bytes:
  - byte 0 = 0xA5, byte 1 = 0x5A;
  - bytes 2..29 = the 28 data bytes;
  - byte 30 = checksum.
- Data byte order: words in the order xyr, xyh, xyl, x, r, xh, xl. Each word is sent MSB byte first.
- Checksum: 8-bit sum modulo 256 of the 28 data bytes. The header is excluded.
- Each byte is sent as start bit (0), data bits 0..7 (LSB first), then stop bit (1).
- FSM states:
  - `IDLE` → `START` when `start` is high;
  - `START` → `DATA` after `BAUD_DIV` cycles;
  - `DATA` → `STOP` after 8 bits;
  - `STOP` → `START` with the next byte if the byte index is below 30, else `IDLE`.
- Snapshot: all seven words are registered on the accept edge. Input changes after that edge do not affect the frame in progress.
- The checksum accumulates over the snapshot bytes as they are loaded; it must not be recomputed from the live inputs.
- Counters:
  - bit timer counts 0..`BAUD_DIV`-1;
  - bit index 0..7;
  - byte index 0..30.
  - None may wrap within a frame.
- `start` while the FSM is not idle:
  - request is ignored and `missed` pulses on that edge;
  - the frame in progress is unaffected.

## Timing

- Reset values (asynchronous, immediate on `rst_n` low): `txd`=1, `busy`=0, `done`=0, `missed`=0, FSM=`IDLE`, all counters, snapshot and checksum = 0.
- Accept edge E (the edge where `start` is sampled high in `IDLE`):
  - after E, `busy`=1 and `txd`=0, with zero idle cycles before the start bit;
  - every bit is held exactly `BAUD_DIV` cycles.
- Frame length: 310 × `BAUD_DIV` cycles. At edge E + 310 × `BAUD_DIV`:
  - FSM returns to `IDLE`, `busy`=0 and `done`=1 for one cycle;
  - `txd` stays 1.
- `start` sampled on the same edge that ends the last stop bit:
  - the FSM is not yet idle, so `missed` pulses;
  - the first accepted `start` is on the following edge.
- `rst_n` low mid-frame:
  - the frame is aborted, `txd`=1 at once, no `done` pulse;
  - after release, a new `start` sends a complete fresh frame.
- `done` and `missed` never stay high for more than one cycle.

## Test plan

Use `BAUD_DIV`=4 unless stated; decode `txd` with a bench UART model.

- Reset: assert `rst_n`=0 mid-run → `txd`=1, `busy`=0, `done`=0, `missed`=0 within the same cycle.
- All inputs 0, pulse `start`:
  - `txd` falls 1 cycle after the accept edge;
  - decoded bytes are A5 5A, then 28×00, then checksum 00;
  - `done` pulses 1240 cycles after the accept edge, and `busy` falls on that same edge.
- `xyr_cnt`=0x01020304, other inputs 0:
  - data bytes 01 02 03 04, then 24×00;
  - checksum 0x0A.
- All inputs 0xFFFFFFFF → 28×FF, checksum 0xE4. Repeat with `BAUD_DIV`=1736 and check each bit lasts 1736 cycles.
- Pulse `start` with inputs 0x11111111, change all inputs to 0x22222222 one cycle later, then pulse `start` at byte 10:
  - `missed` pulses for one cycle;
  - the frame carries all 0x11 data bytes with checksum 0xDC;
  - exactly one `done`.
- Pull `rst_n` low during byte 15, release, then pulse `start` → a full 31-byte fresh frame with correct header and checksum, and no `done` from the aborted frame.

Source files
------------

// File: rtl/freq_result_tx.sv
// UART readout of the seven latched frequency/duty count words as one 31-byte frame:
// A5 5A, 28 snapshot bytes (MSB byte first per word), 8-bit additive checksum; 8N1, no inter-byte gaps.
module freq_result_tx #(
  parameter int BAUD_DIV = 1736
) (
  input  logic        clk200M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] xyr_cnt,
  input  logic [31:0] xyh_cnt,
  input  logic [31:0] xyl_cnt,
  input  logic [31:0] x_cnt,
  input  logic [31:0] r_cnt,
  input  logic [31:0] xh_cnt,
  input  logic [31:0] xl_cnt,
  output logic        txd,
  output logic        busy,
  output logic        done,
  output logic        missed
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [4:0]  BYTE_LAST = 5'd30;
  localparam logic [7:0]  HDR0      = 8'hA5;
  localparam logic [7:0]  HDR1      = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [15:0]  timer_r, timer_s;
  logic [2:0]   bit_idx_r, bit_idx_s;
  logic [4:0]   byte_idx_r, byte_idx_s;
  logic [223:0] snap_r, snap_s;
  logic [7:0]   shift_r, shift_s;
  logic [7:0]   csum_r, csum_s;
  logic         txd_r, txd_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         missed_r, missed_s;
  logic         bit_end_s;
  logic [4:0]   next_idx_s;
  logic [7:0]   next_byte_s;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

  // Next-state, datapath and output decode for the frame sequencer
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    snap_s     = snap_r;
    shift_s    = shift_r;
    csum_s     = csum_r;
    txd_s      = txd_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    missed_s   = 1'b0;

    bit_end_s  = (timer_r == BIT_LAST);
    next_idx_s = byte_idx_r + 5'd1;
    if (next_idx_s == 5'd1) begin
      next_byte_s = HDR1;
    end else if (next_idx_s == BYTE_LAST) begin
      next_byte_s = csum_r;
    end else begin
      next_byte_s = snap_r[223:216];
    end

    if (start && (state_r != IDLE)) begin
      missed_s = 1'b1;
    end else begin
      missed_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = START;
          timer_s    = 16'd0;
          bit_idx_s  = 3'd0;
          byte_idx_s = 5'd0;
          snap_s     = {xyr_cnt, xyh_cnt, xyl_cnt, x_cnt, r_cnt, xh_cnt, xl_cnt};
          shift_s    = HDR0;
          csum_s     = 8'd0;
          txd_s      = 1'b0;
          busy_s     = 1'b1;
        end else begin
          txd_s  = 1'b1;
          busy_s = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          timer_s   = 16'd0;
          bit_idx_s = 3'd0;
          txd_s     = shift_r[0];
          shift_s   = {1'b0, shift_r[7:1]};
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          timer_s = 16'd0;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
            txd_s   = 1'b1;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            txd_s     = shift_r[0];
            shift_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          timer_s = 16'd0;
          if (byte_idx_r < BYTE_LAST) begin
            state_s    = START;
            byte_idx_s = next_idx_s;
            shift_s    = next_byte_s;
            txd_s      = 1'b0;
            // Checksum follows the snapshot bytes as they leave, never the live inputs
            if ((next_idx_s != 5'd1) && (next_idx_s != BYTE_LAST)) begin
              csum_s = csum_add(csum_r, next_byte_s);
              snap_s = {snap_r[215:0], 8'h00};
            end else begin
              csum_s = csum_r;
              snap_s = snap_r;
            end
          end else begin
            state_s = IDLE;
            txd_s   = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        txd_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot and registered outputs
  always_ff @(posedge clk200M or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      timer_r    <= 16'd0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 5'd0;
      snap_r     <= 224'd0;
      shift_r    <= 8'd0;
      csum_r     <= 8'd0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      missed_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      snap_r     <= snap_s;
      shift_r    <= shift_s;
      csum_r     <= csum_s;
      txd_r      <= txd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      missed_r   <= missed_s;
    end
  end

  assign txd    = txd_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign missed = missed_r;

endmodule

// File: tb/tb_freq_result_tx.sv
// Bench for freq_result_tx: frames decoded by a UART sampling model and compared with a
// byte-list reference built from the snapshot words; a second instance checks real bit timing.
module tb_freq_result_tx;

  localparam int BD      = 4;
  localparam int FRAME   = 310 * BD;
  localparam int SLOW_BD = 1736;

  logic clk200M    = 1'b0;
  logic rst_n      = 1'b1;
  logic start      = 1'b0;
  logic rst_slow_n = 1'b1;
  logic start_slow = 1'b0;
  logic [31:0] in_w [7];
  logic [31:0] snap_w [7];
  logic txd, busy, done, missed;
  logic txd_slow, busy_slow, done_slow, missed_slow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int missed_cnt = 0;
  int done_wide = 0;
  int missed_wide = 0;
  logic prev_done = 1'b0;
  logic prev_missed = 1'b0;

  logic [7:0] exp_q [$];
  logic [7:0] got_b [31];
  logic [30:0] framing_ok;
  logic first_txd, first_busy, last_busy, last_done;
  logic end_done, end_busy, end_txd, end_missed;
  int early_done, missed_seen;

  always #5 clk200M = ~clk200M;

  freq_result_tx #(.BAUD_DIV(BD)) dut (
    .clk200M(clk200M), .rst_n(rst_n), .start(start),
    .xyr_cnt(in_w[0]), .xyh_cnt(in_w[1]), .xyl_cnt(in_w[2]), .x_cnt(in_w[3]),
    .r_cnt(in_w[4]), .xh_cnt(in_w[5]), .xl_cnt(in_w[6]),
    .txd(txd), .busy(busy), .done(done), .missed(missed)
  );

  freq_result_tx #(.BAUD_DIV(SLOW_BD)) dut_slow (
    .clk200M(clk200M), .rst_n(rst_slow_n), .start(start_slow),
    .xyr_cnt(in_w[0]), .xyh_cnt(in_w[1]), .xyl_cnt(in_w[2]), .x_cnt(in_w[3]),
    .r_cnt(in_w[4]), .xh_cnt(in_w[5]), .xl_cnt(in_w[6]),
    .txd(txd_slow), .busy(busy_slow), .done(done_slow), .missed(missed_slow)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clk200M) begin
    if (done) done_cnt <= done_cnt + 1;
    if (missed) missed_cnt <= missed_cnt + 1;
    if (done && prev_done) done_wide <= done_wide + 1;
    if (missed && prev_missed) missed_wide <= missed_wide + 1;
    prev_done   <= done;
    prev_missed <= missed;
  end

  task automatic tick();
    @(posedge clk200M);
    #1;
  endtask

  // Reference frame: header, words MSB byte first, sum of data bytes mod 256
  task automatic build_expected();
    int sum;
    logic [7:0] b;
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    sum = 0;
    for (int i = 0; i < 7; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = snap_w[i][8*k +: 8];
        exp_q.push_back(b);
        sum = sum + int'(b);
      end
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic accept();
    for (int i = 0; i < 7; i++) snap_w[i] = in_w[i];
    build_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // UART sampling model: called at accept edge + 1, returns at accept edge + FRAME
  task automatic capture_frame(input int pulse_at, input int change_at,
                               input logic [31:0] change_val, input bit b2b);
    logic [309:0] bits;
    int d0, m0;
    bits = '0;
    d0 = done_cnt;
    m0 = missed_cnt;
    first_txd  = txd;
    first_busy = busy;
    for (int n = 0; n <= FRAME; n++) begin
      if (n < FRAME && (n % BD) == BD / 2) bits[n / BD] = txd;
      if (n == FRAME - 1) begin
        last_busy = busy;
        last_done = done;
      end
      if (n == change_at) for (int i = 0; i < 7; i++) in_w[i] = change_val;
      if (n == pulse_at) start = 1'b1;
      else if (n == pulse_at + 1) start = 1'b0;
      if (b2b && n == FRAME - 1) start = 1'b1;
      if (n < FRAME) tick();
    end
    end_done = done; end_busy = busy; end_txd = txd; end_missed = missed;
    early_done  = done_cnt - d0;
    missed_seen = missed_cnt - m0;
    for (int b = 0; b < 31; b++) begin
      for (int j = 0; j < 8; j++) got_b[b][j] = bits[10*b + 1 + j];
      framing_ok[b] = (bits[10*b] == 1'b0) && (bits[10*b + 9] == 1'b1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 7; i++) in_w[i] = 32'h0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    rst_slow_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || missed !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: txd=%b busy=%b done=%b missed=%b, expected 1 0 0 0", txd, busy, done, missed);
    end
    checks++;
    if (txd_slow !== 1'b1 || busy_slow !== 1'b0) begin
      errors++;
      $display("FAIL reset_slow: txd=%b busy=%b, expected 1 0", txd_slow, busy_slow);
    end
    tick(); tick();
    rst_n = 1'b1;
    rst_slow_n = 1'b1;
    tick(); tick();
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: txd=%b busy=%b, expected 1 0", txd, busy);
    end
  endtask

  task automatic test_patterns();
    int d0;
    logic [7:0] kc;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 7; i++) begin
        case (p)
          0: in_w[i] = 32'h0;
          1: in_w[i] = (i == 0) ? 32'h01020304 : 32'h0;
          2: in_w[i] = 32'hFFFFFFFF;
          default: in_w[i] = $urandom;
        endcase
      end
      d0 = done_cnt;
      accept();
      capture_frame(-1, -1, 32'h0, 1'b0);
      checks++;
      if (first_txd !== 1'b0 || first_busy !== 1'b1) begin
        errors++;
        $display("FAIL pat%0d start_bit: txd=%b busy=%b, expected 0 1", p, first_txd, first_busy);
      end
      checks++;
      if (last_busy !== 1'b1 || last_done !== 1'b0 || end_done !== 1'b1 || end_busy !== 1'b0 ||
          end_txd !== 1'b1 || early_done != 0) begin
        errors++;
        $display("FAIL pat%0d frame_end: done=%b busy=%b txd=%b early=%0d, expected done=1 busy=0 txd=1 early=0",
                 p, end_done, end_busy, end_txd, early_done);
      end
      for (int b = 0; b < 31; b++) begin
        checks++;
        if (got_b[b] !== exp_q[b] || framing_ok[b] !== 1'b1) begin
          errors++;
          $display("FAIL pat%0d byte%0d: got %h framing %b, expected %h framing 1", p, b, got_b[b], framing_ok[b], exp_q[b]);
        end
      end
      if (p < 3) begin
        kc = (p == 0) ? 8'h00 : ((p == 1) ? 8'h0A : 8'hE4);
        checks++;
        if (got_b[30] !== kc) begin
          errors++;
          $display("FAIL pat%0d checksum: got %h, expected %h", p, got_b[30], kc);
        end
      end
      tick(); tick();
      checks++;
      if (done_cnt != d0 + 1 || txd !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL pat%0d idle_after: dones=%0d txd=%b busy=%b, expected 1 1 0", p, done_cnt - d0, txd, busy);
      end
    end
  endtask

  task automatic test_missed_midframe();
    int d0;
    for (int i = 0; i < 7; i++) in_w[i] = 32'h11111111;
    d0 = done_cnt;
    accept();
    capture_frame(10 * 10 * BD + 5, 0, 32'h22222222, 1'b0);
    checks++;
    if (missed_seen != 1) begin
      errors++;
      $display("FAIL mid_missed: pulses=%0d, expected 1", missed_seen);
    end
    for (int b = 0; b < 31; b++) begin
      checks++;
      if (got_b[b] !== exp_q[b] || framing_ok[b] !== 1'b1) begin
        errors++;
        $display("FAIL mid_byte%0d: got %h, expected %h", b, got_b[b], exp_q[b]);
      end
    end
    checks++;
    if (got_b[30] !== 8'hDC || got_b[2] !== 8'h11) begin
      errors++;
      $display("FAIL mid_snapshot: byte2=%h csum=%h, expected 11 DC", got_b[2], got_b[30]);
    end
    tick(); tick();
    checks++;
    if (done_cnt != d0 + 1 || early_done != 0) begin
      errors++;
      $display("FAIL mid_done_count: got %0d, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    for (int i = 0; i < 7; i++) in_w[i] = $urandom;
    d0 = done_cnt;
    accept();
    capture_frame(-1, -1, 32'h0, 1'b1);
    checks++;
    if (end_missed !== 1'b1 || end_done !== 1'b1 || end_busy !== 1'b0 || end_txd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last_edge: missed=%b done=%b busy=%b txd=%b, expected 1 1 0 1", end_missed, end_done, end_busy, end_txd);
    end
    for (int i = 0; i < 7; i++) in_w[i] = $urandom;
    for (int i = 0; i < 7; i++) snap_w[i] = in_w[i];
    build_expected();
    tick();
    start = 1'b0;
    checks++;
    if (missed !== 1'b0 || busy !== 1'b1 || txd !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: missed=%b busy=%b txd=%b, expected 0 1 0", missed, busy, txd);
    end
    capture_frame(-1, -1, 32'h0, 1'b0);
    for (int b = 0; b < 31; b++) begin
      checks++;
      if (got_b[b] !== exp_q[b] || framing_ok[b] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h, expected %h", b, got_b[b], exp_q[b]);
      end
    end
    tick(); tick();
    checks++;
    if (done_cnt != d0 + 2 || end_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    int d0;
    for (int i = 0; i < 7; i++) in_w[i] = $urandom;
    d0 = done_cnt;
    accept();
    for (int n = 0; n < 15 * 10 * BD + 1; n++) tick();
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: txd=%b busy=%b, expected 0 1", txd, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || missed !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: txd=%b busy=%b done=%b missed=%b, expected 1 0 0 0", txd, busy, done, missed);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 700; n++) tick();
    checks++;
    if (done_cnt != d0 || txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_aborted: dones=%0d txd=%b busy=%b, expected 0 1 0", done_cnt - d0, txd, busy);
    end
    for (int i = 0; i < 7; i++) in_w[i] = $urandom;
    accept();
    capture_frame(-1, -1, 32'h0, 1'b0);
    for (int b = 0; b < 31; b++) begin
      checks++;
      if (got_b[b] !== exp_q[b] || framing_ok[b] !== 1'b1) begin
        errors++;
        $display("FAIL rst_fresh_byte%0d: got %h, expected %h", b, got_b[b], exp_q[b]);
      end
    end
    tick(); tick();
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL rst_fresh_done: got %0d, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_slow_baud();
    logic [19:0] sbits;
    logic [7:0] h;
    int bad;
    for (int b = 0; b < 2; b++) begin
      h = (b == 0) ? 8'hA5 : 8'h5A;
      sbits[10*b] = 1'b0;
      for (int j = 0; j < 8; j++) sbits[10*b + 1 + j] = h[j];
      sbits[10*b + 9] = 1'b1;
    end
    start_slow = 1'b1;
    tick();
    start_slow = 1'b0;
    checks++;
    if (busy_slow !== 1'b1 || txd_slow !== 1'b0) begin
      errors++;
      $display("FAIL slow_accept: busy=%b txd=%b, expected 1 0", busy_slow, txd_slow);
    end
    for (int k = 0; k < 20; k++) begin
      bad = 0;
      for (int c = 0; c < SLOW_BD; c++) begin
        if (txd_slow !== sbits[k] || done_slow !== 1'b0 || missed_slow !== 1'b0) bad++;
        tick();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL slow_bit%0d: %0d of %0d cycles differ from level %b", k, bad, SLOW_BD, sbits[k]);
      end
    end
    #2;
    rst_slow_n = 1'b0;
    #1;
    checks++;
    if (txd_slow !== 1'b1 || busy_slow !== 1'b0) begin
      errors++;
      $display("FAIL slow_reset: txd=%b busy=%b, expected 1 0", txd_slow, busy_slow);
    end
  endtask

  task automatic test_pulse_widths();
    checks++;
    if (done_wide != 0 || missed_wide != 0) begin
      errors++;
      $display("FAIL pulse_width: wide done=%0d wide missed=%0d, expected 0 0", done_wide, missed_wide);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_missed_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_slow_baud();
    test_pulse_widths();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
